// File: rtl/key_serial_loader_if.sv
// -----------------------------------------------------------------------------
// key_serial_loader_if
// Serial key-delivery link between the on-chip key transmitter and the
// key_serial_loader receiver.
//
// Signals:
//   start  - one-cycle frame start strobe (transmitter -> receiver)
//   sdata  - serial data bit, MSB first, parity bit last (transmitter -> receiver)
//   svalid - sdata qualifier (transmitter -> receiver)
//   sready - receiver can accept a bit this cycle (receiver -> transmitter)
//
// Modports:
//   master - transmitter side
//   slave  - receiver side
// -----------------------------------------------------------------------------
interface key_serial_loader_if;
  logic start;
  logic sdata;
  logic svalid;
  logic sready;

  modport master (
    output start,
    output sdata,
    output svalid,
    input  sready
  );

  modport slave (
    input  start,
    input  sdata,
    input  svalid,
    output sready
  );
endinterface

// File: rtl/key_serial_loader.sv
// -----------------------------------------------------------------------------
// key_serial_loader
// Receives a KEY_W-bit locking key serially (start strobe, KEY_W data bits
// MSB first, one even-parity bit) into a shadow register and commits it to
// the key output only when the whole frame arrives with correct parity.
//
// Ports:
//   CLK       - rising-edge clock
//   RESET_B   - synchronous active-low reset
//   link      - serial link (slave side): start, sdata, svalid in; sready out
//   key       - committed key
//   key_valid - key holds a good frame
//   busy      - frame in progress
//   err       - sticky parity error of the last frame (cleared by start/reset)
// -----------------------------------------------------------------------------
module key_serial_loader #(
  parameter int KEY_W = 128
) (
  input  logic                CLK,
  input  logic                RESET_B,
  key_serial_loader_if.slave  link,
  output logic [KEY_W-1:0]    key,
  output logic                key_valid,
  output logic                busy,
  output logic                err
);

  localparam int CNT_W = $clog2(KEY_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic [KEY_W-1:0]   r_shadow;
  logic [KEY_W-1:0]   w_shadowNext;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cntNext;
  logic [KEY_W-1:0]   r_key;
  logic [KEY_W-1:0]   w_keyNext;
  logic               r_keyValid;
  logic               w_keyValidNext;
  logic               r_err;
  logic               w_errNext;
  logic               r_sready;
  logic               r_busy;
  logic               w_xfer;
  logic               w_inFrameNext;

  // sready is a flop, so a transfer is qualified only by registered state.
  assign w_xfer        = link.svalid & r_sready;
  assign w_inFrameNext = (w_stateNext != IDLE);

  // Next-state and datapath decode. start has priority over everything,
  // including a bit transfer on the same cycle (that bit is discarded).
  always_comb begin
    w_stateNext    = r_state;
    w_shadowNext   = r_shadow;
    w_cntNext      = r_cnt;
    w_keyNext      = r_key;
    w_keyValidNext = r_keyValid;
    w_errNext      = r_err;

    if (link.start) begin
      w_stateNext  = SHIFT;
      w_shadowNext = '0;
      w_cntNext    = '0;
      w_errNext    = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
        end
        SHIFT: begin
          if (w_xfer) begin
            w_shadowNext = {r_shadow[KEY_W-2:0], link.sdata};
            w_cntNext    = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(KEY_W - 1)) begin
              w_stateNext = PARITY;
            end
          end
        end
        PARITY: begin
          if (w_xfer) begin
            // Even parity: the parity bit must equal the XOR of the data bits.
            if (link.sdata == ^r_shadow) begin
              w_keyNext      = r_shadow;
              w_keyValidNext = 1'b1;
              w_errNext      = 1'b0;
            end else begin
              w_keyValidNext = 1'b0;
              w_errNext      = 1'b1;
            end
            w_stateNext = IDLE;
          end
        end
        default: begin
          w_stateNext = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers. sready/busy are registered copies of
  // "next state is SHIFT or PARITY", so they track the state with no
  // combinational path from svalid.
  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      r_state    <= IDLE;
      r_shadow   <= '0;
      r_cnt      <= '0;
      r_key      <= '0;
      r_keyValid <= 1'b0;
      r_err      <= 1'b0;
      r_sready   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_shadow   <= w_shadowNext;
      r_cnt      <= w_cntNext;
      r_key      <= w_keyNext;
      r_keyValid <= w_keyValidNext;
      r_err      <= w_errNext;
      r_sready   <= w_inFrameNext;
      r_busy     <= w_inFrameNext;
    end
  end

  assign link.sready = r_sready;
  assign key         = r_key;
  assign key_valid   = r_keyValid;
  assign busy        = r_busy;
  assign err         = r_err;

endmodule
